otter_branch_predictor: RTL and testbench

OTTER_BRANCH_PREDICTOR -- requirements
Module: otter_branch_predictor

---
 rtl/otter_branch_predictor.sv | 145 ++++++++++++++
 tb/tb_otter_branch_predictor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with saturating counters and a
// one-cycle registered lookup. Define BPU_PERF_CNT_EN to add lookup/mispredict counters.
module otter_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispred_i
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0] lookup_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic idx_t pc_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic tag_t pc_tag(input logic [31:0] pc);
    return pc[IDX_W+2 +: TAG_W];
  endfunction

  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic        pred_valid_q;
  logic        pred_taken_q;
  logic [31:0] pred_target_q;

  idx_t             f_idx, u_idx;
  logic             f_hit, f_taken, u_hit;
  logic [31:0]      f_target;
  logic [CTR_W-1:0] ctr_d;

  // Lookup side: all of this reads the pre-edge array, giving read-before-write.
  always_comb begin
    f_idx    = pc_idx(fetch_pc_i);
    f_hit    = valid_q[f_idx] && (tag_q[f_idx] == pc_tag(fetch_pc_i));
    f_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
    f_target = f_taken ? target_q[f_idx] : fetch_pc_i + 32'd4;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    u_idx = pc_idx(upd_pc_i);
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == pc_tag(upd_pc_i));
    ctr_d = ctr_q[u_idx];
    if (!u_hit) begin
      ctr_d = upd_taken_i ? CTR_WT : CTR_WNT;
    end else if (upd_taken_i) begin
      if (ctr_q[u_idx] != CTR_MAX) ctr_d = ctr_q[u_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[u_idx] != '0) ctr_d = ctr_q[u_idx] - CTR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; where two land on the same
  // bit in one edge the later one wins, which is how flush overrides an allocation.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else begin
      if (upd_valid_i) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= ctr_d;
      end
      if (flush_i) valid_q <= '0;
    end
  end

  // NOTE: tags and targets are left out of reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i) begin
      tag_q[u_idx] <= pc_tag(upd_pc_i);
      if (!u_hit || upd_taken_i) target_q[u_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (!stall_i) begin
      pred_valid_q  <= 1'b1;
      pred_taken_q  <= f_taken;
      pred_target_q <= f_target;
    end
  end

  assign pred_valid_o  = pred_valid_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] lookup_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (!stall_i && lookup_cnt_q != '1) lookup_cnt_q <= lookup_cnt_q + 32'd1;
      if (upd_valid_i && upd_mispred_i && mispred_cnt_q != '1)
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign lookup_cnt_o  = lookup_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[1:0], fetch_pc_i[31:IDX_W+2+TAG_W],
                            upd_pc_i[1:0], upd_pc_i[31:IDX_W+2+TAG_W]};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[1:0], fetch_pc_i[31:IDX_W+2+TAG_W],
                            upd_pc_i[1:0], upd_pc_i[31:IDX_W+2+TAG_W], upd_mispred_i};
`endif

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Self-checking bench for otter_branch_predictor: directed scenarios plus randomized
// traffic against a table-of-entries reference model.
module tb_otter_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int CTR_W   = 2;
  localparam int TAG_W   = 8;
  localparam int HALF    = 1 << (CTR_W - 1);
  localparam int CMAX    = (1 << CTR_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] lookup_cnt, mispred_cnt;
`endif

  otter_branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .fetch_pc_i   (fetch_pc),
    .pred_valid_o (pred_valid),
    .pred_taken_o (pred_taken),
    .pred_target_o(pred_target),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target),
    .upd_mispred_i(upd_mispred)
`ifdef BPU_PERF_CNT_EN
    ,
    .lookup_cnt_o (lookup_cnt),
    .mispred_cnt_o(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per table slot, counters kept as plain integers.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          e_valid, e_taken;
  logic [31:0] e_target;
  int          m_lookups, m_mispred;

  function automatic int pc2idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int pc2tag(input logic [31:0] pc);
    return int'((pc >> (2 + $clog2(ENTRIES))) % (1 << TAG_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = HALF - 1;
    end
    e_valid = 1'b0; e_taken = 1'b0; e_target = '0;
    m_lookups = 0; m_mispred = 0;
  endtask

  task automatic model_edge();
    int fi, ui;
    bit fhit, uhit;
    fi   = pc2idx(fetch_pc);
    ui   = pc2idx(upd_pc);
    fhit = m_valid[fi] && (m_tag[fi] == pc2tag(fetch_pc));
    uhit = m_valid[ui] && (m_tag[ui] == pc2tag(upd_pc));
    if (!stall) begin
      e_valid  = 1'b1;
      e_taken  = fhit && (m_ctr[fi] >= HALF);
      e_target = e_taken ? m_tgt[fi] : fetch_pc + 32'd4;
      m_lookups++;
    end
    if (upd_valid) begin
      if (uhit) begin
        if (upd_taken) begin
          m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
          m_tgt[ui] = upd_target;
        end else begin
          m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
        end
      end else begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = pc2tag(upd_pc);
        m_tgt[ui]   = upd_target;
        m_ctr[ui]   = upd_taken ? HALF : HALF - 1;
      end
      if (upd_mispred) m_mispred++;
    end
    if (flush) for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_pc = pc;
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({pred_valid, pred_taken, pred_target} !== 34'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got v=%b t=%b tgt=%h, want all zero",
               pred_valid, pred_taken, pred_target);
    end
`ifdef BPU_PERF_CNT_EN
    n_checks++;
    if ({lookup_cnt, mispred_cnt} !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset_counters: got %0d/%0d, want 0/0", lookup_cnt, mispred_cnt);
    end
`endif
    @(negedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic compare(input string name);
    n_checks++;
    if ({pred_valid, pred_taken, pred_target} !== {e_valid, e_taken, e_target}) begin
      n_fail++;
      $display("FAIL %s: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h", name,
               pred_valid, pred_taken, pred_target, e_valid, e_taken, e_target);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (pred_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_held: got %b, want 0", pred_valid);
    end
  endtask

  task automatic test_basic_lookup();
    lookup(32'h100);
    n_checks++;
    if ({pred_valid, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL first_lookup: got v=%b t=%b tgt=%h, want v=1 t=0 tgt=00000104",
               pred_valid, pred_taken, pred_target);
    end
    compare("first_lookup_model");
  endtask

  task automatic test_training();
    update(32'h100, 1'b1, 32'h80);
    lookup(32'h100);
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h80}) begin
      n_fail++;
      $display("FAIL trained_taken: got t=%b tgt=%h, want t=1 tgt=00000080",
               pred_taken, pred_target);
    end
    for (int i = 0; i < 3; i++) update(32'h100, 1'b0, 32'h999);
    lookup(32'h100);
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL trained_not_taken: got t=%b tgt=%h, want t=0 tgt=00000104",
               pred_taken, pred_target);
    end
    update(32'h100, 1'b0, 32'h999);
    update(32'h100, 1'b1, 32'h88);
    lookup(32'h100);
    compare("saturate_low_then_one_taken");
    update(32'h100, 1'b1, 32'h8C);
    lookup(32'h100);
    compare("two_taken_after_floor");
  endtask

  task automatic test_alias();
    update(32'h100, 1'b1, 32'h80);
    lookup(32'h200);
    compare("alias_tag_miss");
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h204}) begin
      n_fail++;
      $display("FAIL alias_literal: got t=%b tgt=%h, want t=0 tgt=00000204",
               pred_taken, pred_target);
    end
  endtask

  task automatic test_same_edge();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_pc = 32'h300;
    update(32'h300, 1'b1, 32'h500);
    compare("same_edge_read_before_write");
    lookup(32'h300);
    compare("same_edge_next_lookup");
  endtask

  task automatic test_stall_flush();
    update(32'h3F0, 1'b1, 32'h1234);
    lookup(32'h3F0);
    compare("stall_setup");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc   = 32'h1000 + 32'(i * 4);
      upd_valid  = 1'b1; upd_pc = 32'h3F0; upd_taken = 1'b0;
      flush      = (i == 1);
      tick();
      compare("stall_hold");
    end
    idle();
    update(32'h400, 1'b1, 32'h4444);
    flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = 1'b1; upd_target = 32'h5555;
    tick();
    idle();
    lookup(32'h400);
    compare("flush_beats_update");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      upd_valid  = $urandom_range(0, 1);
      upd_taken  = $urandom_range(0, 1);
      upd_mispred = $urandom_range(0, 1);
      upd_target = $urandom;
      fetch_pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upd_pc     = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) fetch_pc = $urandom;
      tick();
      compare("random");
`ifdef BPU_PERF_CNT_EN
      n_checks++;
      if ({lookup_cnt, mispred_cnt} !== {32'(m_lookups), 32'(m_mispred)}) begin
        n_fail++;
        $display("FAIL random_counters: got %0d/%0d, want %0d/%0d",
                 lookup_cnt, mispred_cnt, m_lookups, m_mispred);
      end
`endif
    end
    idle();
  endtask

  task automatic test_reset_mid_update();
    update(32'h700, 1'b1, 32'h7777);
    lookup(32'h700);
    compare("pre_reset_hit");
    upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h1;
    apply_reset();
    lookup(32'h700);
    compare("post_reset_first_lookup");
    n_checks++;
    if ({pred_valid, pred_taken} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_entry_invalid: got v=%b t=%b, want v=1 t=0",
               pred_valid, pred_taken);
    end
  endtask

`ifdef BPU_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      upd_valid = (i == 2 || i == 6); upd_mispred = 1'b1;
      upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h0;
      tick();
    end
    idle();
    n_checks++;
    if ({lookup_cnt, mispred_cnt} !== {32'd10, 32'd2}) begin
      n_fail++;
      $display("FAIL perf_counts: got %0d/%0d, want 10/2", lookup_cnt, mispred_cnt);
    end
    stall = 1'b1; flush = 1'b1;
    tick();
    idle();
    n_checks++;
    if ({lookup_cnt, mispred_cnt} !== {32'(m_lookups), 32'(m_mispred)}) begin
      n_fail++;
      $display("FAIL perf_flush_stall: got %0d/%0d, want %0d/%0d",
               lookup_cnt, mispred_cnt, m_lookups, m_mispred);
    end
  endtask
`endif

  initial begin
    idle();
    model_reset();
    test_reset();
    test_basic_lookup();
    test_training();
    test_alias();
    test_same_edge();
    test_stall_flush();
    test_random();
    test_reset_mid_update();
`ifdef BPU_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
